// File: rtl/if_stage_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package if_stage_pkg;

  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

  typedef enum logic {
    FETCH    = 1'b0,
    WAIT_MEM = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic        taken;
    logic [31:0] target;
  } redirect_t;

  function automatic logic [31:0] align4(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_pc_reg.sv
// PC register, next-PC selection and pending-redirect tracking for an in-flight fetch.
module pc_reg
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  redirect_t   br,
  input  redirect_t   jp,
  input  logic        stall,
  input  logic        imem_ready,
  input  logic        in_wait,
  output logic [31:0] pc,
  output logic        pending
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc      <= RESET_PC;
      pending <= 1'b0;
    end else if (br.taken) begin
      pc <= align4(br.target);
      if (in_wait) pending <= 1'b1;
    end else if (jp.taken) begin
      pc <= align4(jp.target);
      if (in_wait) pending <= 1'b1;
    end else if (!stall && imem_ready) begin
      // the word for the abandoned address is dropped; refetch at the new PC
      if (pending) pending <= 1'b0;
      else         pc      <= pc + 32'd4;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC, IF/ID register and memory-wait FSM.
// Optional IF_DELAY_SLOT_EN: jumps keep the delay-slot instruction and never flush ID/EX.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid,
  output logic [5:0]  opcode,
  output logic [5:0]  functcode,
  output logic        idex_flush
);

  fetch_state_e state;
  logic [31:0]  pc;
  logic         pending;
  redirect_t    br, jp;
  logic         take_word;

  assign br        = {branch_taken, branch_target};
  assign jp        = {jump, jump_target};
  assign take_word = imem_ready && !pending;

  pc_reg #(.RESET_PC(RESET_PC)) u_pc (
    .clk        (clk),
    .reset      (reset),
    .br         (br),
    .jp         (jp),
    .stall      (stall),
    .imem_ready (imem_ready),
    .in_wait    (state == WAIT_MEM),
    .pc         (pc),
    .pending    (pending)
  );

  assign imem_addr = pc;
  assign opcode    = ifid_instr[31:26];
  assign functcode = ifid_instr[5:0];

`ifdef IF_DELAY_SLOT_EN
  assign idex_flush = 1'b0;
`else
  assign idex_flush = branch_taken;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ifid_instr <= NOP_INSTR;
      ifid_pc4   <= 32'd0;
      ifid_valid <= 1'b0;
      state      <= FETCH;
    end else if (branch_taken) begin
      ifid_instr <= NOP_INSTR;
      ifid_valid <= 1'b0;
    end else if (jump) begin
`ifdef IF_DELAY_SLOT_EN
      if (take_word) begin
        ifid_instr <= imem_rdata;
        ifid_pc4   <= pc + 32'd4;
        ifid_valid <= 1'b1;
      end else begin
        ifid_instr <= NOP_INSTR;
        ifid_valid <= 1'b0;
      end
`else
      ifid_instr <= NOP_INSTR;
      ifid_valid <= 1'b0;
`endif
    end else if (!stall) begin
      case (state)
        FETCH:    if (!imem_ready) state <= WAIT_MEM;
        WAIT_MEM: if (imem_ready)  state <= FETCH;
        default:  state <= FETCH;
      endcase
      if (take_word) begin
        ifid_instr <= imem_rdata;
        ifid_pc4   <= pc + 32'd4;
        ifid_valid <= 1'b1;
      end else begin
        ifid_instr <= NOP_INSTR;
        ifid_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: vector table through a scoreboard plus a reset-in-wait sequence.
module tb_if_stage;

`ifdef IF_DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif
  localparam int NV = 22;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, branch_taken, jump, imem_ready;
  logic [31:0] branch_target, jump_target, imem_rdata;
  logic [31:0] imem_addr, ifid_instr, ifid_pc4;
  logic        ifid_valid, idex_flush;
  logic [5:0]  opcode, functcode;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  if_stage dut (
    .clk(clk), .reset(reset), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .ifid_instr(ifid_instr), .ifid_pc4(ifid_pc4), .ifid_valid(ifid_valid),
    .opcode(opcode), .functcode(functcode), .idex_flush(idex_flush)
  );

  typedef struct {
    logic        st, bt;
    logic [31:0] btgt;
    logic        jm;
    logic [31:0] jtgt;
    logic        rdy;
    logic [31:0] rdata;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] instr;
    logic        cp;
    logic [31:0] pc4;
    logic        flush;
  } vec_t;

  typedef struct {
    int          idx;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] instr;
    logic        cp;
    logic [31:0] pc4;
    logic        flush;
  } exp_t;

  vec_t tbl[NV];
  exp_t sbq[$];

  function automatic logic [31:0] w(input logic [31:0] a);
    return 32'h8C00_0000 | {8'h00, a[23:0]};
  endfunction

  function automatic vec_t mk(input logic st, input logic bt, input logic [31:0] btgt,
                              input logic jm, input logic [31:0] jtgt,
                              input logic rdy, input logic [31:0] rdata,
                              input logic [31:0] addr, input logic valid,
                              input logic [31:0] instr, input logic cp,
                              input logic [31:0] pc4);
    vec_t v;
    v.st = st; v.bt = bt; v.btgt = btgt; v.jm = jm; v.jtgt = jtgt;
    v.rdy = rdy; v.rdata = rdata; v.addr = addr; v.valid = valid;
    v.instr = instr; v.cp = cp; v.pc4 = pc4;
    v.flush = DS ? 1'b0 : bt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    //         st bt btgt           jm jtgt          rdy rdata            addr           vld instr                      cp pc4
    tbl[0]  = mk(0, 0, 0,            0, 0,           1, w(32'h0),        32'h4,          1, w(32'h0),                  1, 32'h4);
    tbl[1]  = mk(0, 0, 0,            0, 0,           1, w(32'h4),        32'h8,          1, w(32'h4),                  1, 32'h8);
    tbl[2]  = mk(1, 0, 0,            0, 0,           1, w(32'h8),        32'h8,          1, w(32'h4),                  1, 32'h8);
    tbl[3]  = mk(1, 0, 0,            0, 0,           1, w(32'h8),        32'h8,          1, w(32'h4),                  1, 32'h8);
    tbl[4]  = mk(0, 0, 0,            0, 0,           1, w(32'h8),        32'hC,          1, w(32'h8),                  1, 32'hC);
    tbl[5]  = mk(1, 1, 32'h40,       0, 0,           1, w(32'hC),        32'h40,         0, 32'h0,                     0, 32'h0);
    tbl[6]  = mk(0, 0, 0,            0, 0,           1, w(32'h40),       32'h44,         1, w(32'h40),                 1, 32'h44);
    tbl[7]  = mk(0, 1, 32'h24,       0, 0,           1, w(32'h44),       32'h24,         0, 32'h0,                     0, 32'h0);
    tbl[8]  = mk(0, 0, 0,            1, 32'h100,     1, w(32'h24),       32'h100,        DS, DS ? w(32'h24) : 32'h0,   DS, 32'h28);
    tbl[9]  = mk(0, 0, 0,            0, 0,           1, w(32'h100),      32'h104,        1, w(32'h100),                1, 32'h104);
    tbl[10] = mk(0, 0, 0,            0, 0,           0, 32'h0,           32'h104,        0, 32'h0,                     0, 32'h0);
    tbl[11] = mk(0, 0, 0,            1, 32'h200,     0, 32'h0,           32'h200,        0, 32'h0,                     0, 32'h0);
    tbl[12] = mk(0, 0, 0,            0, 0,           0, 32'h0,           32'h200,        0, 32'h0,                     0, 32'h0);
    tbl[13] = mk(0, 0, 0,            0, 0,           1, w(32'h104),      32'h200,        0, 32'h0,                     0, 32'h0);
    tbl[14] = mk(0, 0, 0,            0, 0,           1, w(32'h200),      32'h204,        1, w(32'h200),                1, 32'h204);
    tbl[15] = mk(0, 1, 32'hFFFF_FFFF, 0, 0,          1, w(32'h204),      32'hFFFF_FFFC,  0, 32'h0,                     0, 32'h0);
    tbl[16] = mk(0, 0, 0,            0, 0,           1, w(32'hFFFF_FFFC), 32'h0,         1, w(32'hFFFF_FFFC),          1, 32'h0);
    tbl[17] = mk(0, 0, 0,            0, 0,           0, 32'h0,           32'h0,          0, 32'h0,                     0, 32'h0);
    tbl[18] = mk(0, 1, 32'h80,       0, 0,           0, 32'h0,           32'h80,         0, 32'h0,                     0, 32'h0);
    tbl[19] = mk(0, 0, 0,            1, 32'h92,      0, 32'h0,           32'h90,         0, 32'h0,                     0, 32'h0);
    tbl[20] = mk(0, 0, 0,            0, 0,           1, 32'hDEAD_BEEF,   32'h90,         0, 32'h0,                     0, 32'h0);
    tbl[21] = mk(0, 0, 0,            0, 0,           1, w(32'h90),       32'h94,         1, w(32'h90),                 1, 32'h94);

    reset = 1'b1; stall = 0; branch_taken = 0; jump = 0; imem_ready = 0;
    branch_target = 0; jump_target = 0; imem_rdata = 0;
    repeat (2) @(negedge clk);
    chk("reset_addr",  imem_addr, 32'h0);
    chk("reset_valid", {31'd0, ifid_valid}, 32'd0);
    chk("reset_instr", ifid_instr, 32'h0);
    chk("reset_pc4",   ifid_pc4, 32'h0);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      reset         = 1'b0;
      stall         = tbl[i].st;
      branch_taken  = tbl[i].bt;
      branch_target = tbl[i].btgt;
      jump          = tbl[i].jm;
      jump_target   = tbl[i].jtgt;
      imem_ready    = tbl[i].rdy;
      imem_rdata    = tbl[i].rdata;
      sbq.push_back('{idx: i, addr: tbl[i].addr, valid: tbl[i].valid, instr: tbl[i].instr,
                      cp: tbl[i].cp, pc4: tbl[i].pc4, flush: tbl[i].flush});
      @(posedge clk); #1;
      if (sbq.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL scoreboard_empty: vector %0d", i);
      end else begin
        e = sbq.pop_front();
        chk($sformatf("v%0d_addr", e.idx),  imem_addr, e.addr);
        chk($sformatf("v%0d_valid", e.idx), {31'd0, ifid_valid}, {31'd0, e.valid});
        chk($sformatf("v%0d_instr", e.idx), ifid_instr, e.instr);
        chk($sformatf("v%0d_opcode", e.idx), {26'd0, opcode}, {26'd0, e.instr[31:26]});
        chk($sformatf("v%0d_funct", e.idx),  {26'd0, functcode}, {26'd0, e.instr[5:0]});
        chk($sformatf("v%0d_flush", e.idx), {31'd0, idex_flush}, {31'd0, e.flush});
        if (e.cp) chk($sformatf("v%0d_pc4", e.idx), ifid_pc4, e.pc4);
      end
    end

    // reset pulse while a fetch is outstanding
    @(negedge clk);
    stall = 0; branch_taken = 0; jump = 0; imem_ready = 0; imem_rdata = 0;
    @(posedge clk); #1;
    chk("wait_addr", imem_addr, 32'h94);
    #2 reset = 1'b1;
    #1;
    chk("midwait_reset_addr",  imem_addr, 32'h0);
    chk("midwait_reset_valid", {31'd0, ifid_valid}, 32'd0);
    @(negedge clk);
    reset = 1'b0; imem_ready = 1'b1; imem_rdata = w(32'h0);
    @(posedge clk); #1;
    chk("post_reset_addr",  imem_addr, 32'h4);
    chk("post_reset_instr", ifid_instr, w(32'h0));
    chk("post_reset_valid", {31'd0, ifid_valid}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
